// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes, state encodings and the power-up command list.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLR           = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] SET_DDRAM     = 8'h80;
    localparam logic [7:0] ROW1_BASE     = 8'h40;
    localparam int         INIT_LEN      = 6;

    typedef enum logic [1:0] {S_PWRUP, S_INIT, S_ADDR, S_CHAR} main_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SETUP, T_EN, T_WAIT} xfer_state_t;

    // Function set is sent three times so the panel syncs to 8-bit mode from any state.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_cmd = FUNC_SET_8B2L;
            3'd3:             init_cmd = DISP_ON;
            3'd4:             init_cmd = CLR;
            default:          init_cmd = ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Character write port: one cell per accepted valid/ready beat.
interface lcd_hd44780_ctrl_if #(
    parameter int ROW_W = 1
);
    logic             wr_valid;
    logic             wr_ready;
    logic [ROW_W-1:0] wr_row;
    logic [5:0]       wr_col;
    logic [7:0]       wr_char;

    modport master (output wr_valid, wr_row, wr_col, wr_char, input wr_ready);
    modport slave  (input wr_valid, wr_row, wr_col, wr_char, output wr_ready);
endinterface

// File: rtl/lcd_byte_xfer.sv
// Single-byte HD44780 bus cycle: setup, enable strobe, then post-byte wait; done pulses once at the end.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 25,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    xfer_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_last;

    // RS/DATA are only loaded on start, so they stay put through setup, strobe and wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= T_IDLE;
            cnt       <= '0;
            wait_last <= '0;
            done      <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                T_IDLE: begin
                    if (start) begin
                        state     <= T_SETUP;
                        cnt       <= '0;
                        lcd_rs    <= rs;
                        lcd_data  <= data;
                        wait_last <= (!rs && data == CLR) ? CLR_LAST : CMD_LAST;
                    end
                end
                T_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state  <= T_EN;
                        cnt    <= '0;
                        lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                T_EN: begin
                    if (cnt == EN_LAST) begin
                        state  <= T_WAIT;
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                T_WAIT: begin
                    if (cnt == wait_last) begin
                        state <= T_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 controller: power-up init, then endless refresh of the panel from a local character buffer.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 16,
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int EN_CYC       = 25,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_hd44780_ctrl_if.slave   wr,
    input  logic                bl_en,
    output logic                init_done,
    output logic                LCD_ON,
    output logic                LCD_BLON,
    output logic                LCD_EN,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic [7:0]          LCD_DATA
);

    localparam int MAX_CYC = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NCELL   = ROWS * COLS;
    localparam int IDX_W   = (NCELL > 1) ? $clog2(NCELL) : 1;

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [2:0]       INIT_LAST  = 3'(INIT_LEN - 1);

    main_state_t      state;
    logic [CNT_W-1:0] pwr_cnt;
    logic [2:0]       init_idx;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             busy;
    logic             start;
    logic             done;
    logic             xfer_rs;
    logic [7:0]       xfer_data;
    logic             ready_q;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       cells [NCELL];

    assign wr.wr_ready = ready_q;
    assign LCD_RW      = 1'b0;

    // Out-of-range writes still complete the handshake; they just never touch the buffer.
    assign wr_hit = wr.wr_valid && ready_q &&
                    (int'(wr.wr_row) < ROWS) && (int'(wr.wr_col) < COLS);
    assign wr_idx = IDX_W'(int'(wr.wr_row) * COLS + int'(wr.wr_col));
    assign rd_idx = IDX_W'(int'(row) * COLS + int'(col));
    assign start  = (state != S_PWRUP) && !busy;

    always_comb begin
        xfer_rs   = 1'b0;
        xfer_data = 8'h00;
        case (state)
            S_INIT: xfer_data = init_cmd(init_idx);
            S_ADDR: xfer_data = SET_DDRAM | ((row != '0) ? ROW1_BASE : 8'h00);
            S_CHAR: begin
                xfer_rs   = 1'b1;
                xfer_data = cells[rd_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELL; i++) cells[i] <= 8'h20;
        end else if (wr_hit) begin
            cells[wr_idx] <= wr.wr_char;
        end
    end

    // Each non-power-up state issues one byte, then advances on the transfer's done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_PWRUP;
            pwr_cnt   <= '0;
            init_idx  <= '0;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            ready_q   <= 1'b0;
            LCD_ON    <= 1'b0;
            LCD_BLON  <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            LCD_ON   <= 1'b1;
            LCD_BLON <= bl_en;
            if (start)     busy <= 1'b1;
            else if (done) busy <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt == PWRUP_LAST) state <= S_INIT;
                    else                        pwr_cnt <= pwr_cnt + 1'b1;
                end
                S_INIT: begin
                    if (done) begin
                        if (init_idx == INIT_LAST) begin
                            state     <= S_ADDR;
                            row       <= '0;
                            init_done <= 1'b1;
                        end else begin
                            init_idx <= init_idx + 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (done) begin
                        state <= S_CHAR;
                        col   <= '0;
                    end
                end
                S_CHAR: begin
                    if (done) begin
                        if (col == COL_LAST) begin
                            state <= S_ADDR;
                            row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

    lcd_byte_xfer #(
        .SETUP_CYC    (SETUP_CYC),
        .EN_CYC       (EN_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .CNT_W        (CNT_W)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rs       (xfer_rs),
        .data     (xfer_data),
        .done     (done),
        .lcd_en   (LCD_EN),
        .lcd_rs   (LCD_RS),
        .lcd_data (LCD_DATA)
    );

endmodule
